// File: rtl/cfu_requant_pkg.sv
// Shared types and constants for the cfu_requant int8 requantization pipeline.
package cfu_requant_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned SH_W  = 6;
    localparam int unsigned LANES = ACC_W / OUT_W;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [SEL_W-1:0] {
        REQ_BIAS    = 3'd0,
        REQ_MULT    = 3'd1,
        REQ_SHIFT   = 3'd2,
        REQ_OFFSET  = 3'd3,
        REQ_ACT_MIN = 3'd4,
        REQ_ACT_MAX = 3'd5
    } req_sel_e;

    localparam logic [ACC_W-1:0] REQ_MULT_DEFAULT = 32'h4000_0000;
    localparam logic [ACC_W-1:0] INT8_MIN         = 32'hFFFF_FF80;
    localparam logic [ACC_W-1:0] INT8_MAX         = 32'h0000_007F;
    localparam logic [ACC_W-1:0] INT32_MIN        = 32'h8000_0000;
    localparam logic [ACC_W-1:0] INT32_MAX        = 32'h7FFF_FFFF;

endpackage

// File: rtl/cfu_requant_srdhm.sv
// Saturating rounding doubling high multiply: y = round(a*b / 2^31), INT32_MIN^2 saturates.
module cfu_srdhm
    import cfu_requant_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    output logic [ACC_W-1:0] y_o
);

    localparam int unsigned P_W = 2 * ACC_W;
    localparam logic signed [P_W-1:0] NUDGE_POS = 64'sd1 <<< 30;
    localparam logic signed [P_W-1:0] NUDGE_NEG = 64'sd1 - NUDGE_POS;

    logic signed [ACC_W-1:0] a_s;
    logic signed [ACC_W-1:0] b_s;
    logic signed [P_W-1:0]   prod;
    logic signed [P_W-1:0]   sum;

    always_comb begin
        a_s  = a_i;
        b_s  = b_i;
        prod = P_W'(a_s) * P_W'(b_s);
        sum  = prod + (prod[P_W-1] ? NUDGE_NEG : NUDGE_POS);
        y_o  = ACC_W'(sum >>> 31);
        if (a_i == INT32_MIN && b_i == INT32_MIN) begin
            y_o = INT32_MAX;
        end
    end

endmodule

// File: rtl/cfu_requant.sv
// 4-stage valid/ready int8 requantizer (bias, SRDHM, rounding shift, offset, clamp).
// Define CFU_REQUANT_PACK_EN to pack four int8 results per 32-bit output word.
module cfu_requant
    import cfu_requant_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [ACC_W-1:0] cfg_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_acc,
    input  logic             in_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    logic [ACC_W-1:0] bias_q, mult_q, off_q, amin_q, amax_q;
    logic [SH_W-1:0]  shift_q;

    logic             s1_v_q, s2_v_q, s3_v_q;
    logic [ACC_W-1:0] s1_x_q, s2_y_q, s3_z_q;
    logic [ACC_W-1:0] s1_x_d, s2_y_d, s3_z_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             stall, adv;

    // Config bank, read live by all stages
    always_ff @(posedge clk) begin
        if (reset) begin
            bias_q  <= '0;
            mult_q  <= REQ_MULT_DEFAULT;
            shift_q <= '0;
            off_q   <= '0;
            amin_q  <= INT8_MIN;
            amax_q  <= INT8_MAX;
        end else if (cfg_valid) begin
            case (req_sel_e'(cfg_sel))
                REQ_BIAS:    bias_q  <= cfg_data;
                REQ_MULT:    mult_q  <= cfg_data;
                REQ_SHIFT:   shift_q <= cfg_data[SH_W-1:0];
                REQ_OFFSET:  off_q   <= cfg_data;
                REQ_ACT_MIN: amin_q  <= cfg_data;
                REQ_ACT_MAX: amax_q  <= cfg_data;
                default: ;
            endcase
        end
    end

    assign stall    = out_valid_q & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = adv;
    assign busy     = s1_v_q | s2_v_q | s3_v_q | out_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // S1: bias add and optional left shift
    always_comb begin
        s1_x_d = in_acc + bias_q;
        if (!shift_q[SH_W-1] && shift_q != '0) begin
            s1_x_d = s1_x_d << shift_q[SH_W-2:0];
        end
    end

    // S2: fixed-point multiply
    cfu_srdhm u_srdhm (
        .a_i (s1_x_q),
        .b_i (mult_q),
        .y_o (s2_y_d)
    );

    // S3: rounding right shift, half away from zero
    logic [4:0]       rs_e;
    logic [ACC_W-1:0] rs_mask, rs_rem, rs_th, rs_sh;
    always_comb begin
        rs_e    = 5'(-shift_q);
        rs_mask = (ACC_W'(1) << rs_e) - ACC_W'(1);
        rs_rem  = s2_y_q & rs_mask;
        rs_th   = (rs_mask >> 1) + ACC_W'(s2_y_q[ACC_W-1]);
        rs_sh   = $signed(s2_y_q) >>> rs_e;
        s3_z_d  = s2_y_q;
        if (shift_q[SH_W-1]) begin
            s3_z_d = rs_sh + ACC_W'(rs_rem > rs_th);
        end
    end

    // S4: output offset and activation clamp
    logic [ACC_W-1:0] cl_w, cl_res;
    logic [OUT_W-1:0] res8;
    always_comb begin
        cl_w   = s3_z_q + off_q;
        cl_res = cl_w;
        if ($signed(cl_w) < $signed(amin_q)) begin
            cl_res = amin_q;
        end else if ($signed(cl_w) > $signed(amax_q)) begin
            cl_res = amax_q;
        end
        res8 = OUT_W'(cl_res);
    end

`ifdef CFU_REQUANT_PACK_EN
    logic              s1_f_q, s2_f_q, s3_f_q;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ACC_W-1:0]  pbuf_q, pbuf_d, word;

    // Lane packer: emit on the fourth lane or a flushed element
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lane_d      = lane_q;
        pbuf_d      = pbuf_q;
        word        = pbuf_q | (ACC_W'(res8) << {lane_q, 3'b000});
        if (adv) begin
            out_valid_d = 1'b0;
            if (s3_v_q) begin
                if (lane_q == LANE_W'(LANES - 1) || s3_f_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = word;
                    pbuf_d      = '0;
                    lane_d      = '0;
                end else begin
                    pbuf_d = word;
                    lane_d = lane_q + LANE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_f_q <= 1'b0;
            s2_f_q <= 1'b0;
            s3_f_q <= 1'b0;
            lane_q <= '0;
            pbuf_q <= '0;
        end else begin
            lane_q <= lane_d;
            pbuf_q <= pbuf_d;
            if (adv) begin
                s1_f_q <= in_flush & in_valid;
                s2_f_q <= s1_f_q;
                s3_f_q <= s2_f_q;
            end
        end
    end
`else
    logic unused_flush;
    assign unused_flush = in_flush;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv) begin
            out_valid_d = s3_v_q;
            if (s3_v_q) begin
                out_data_d = {{(ACC_W - OUT_W){res8[OUT_W-1]}}, res8};
            end
        end
    end
`endif

    // Stage valids and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s2_v_q      <= 1'b0;
            s3_v_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (adv) begin
                s1_v_q <= in_valid;
                s2_v_q <= s1_v_q;
                s3_v_q <= s2_v_q;
            end
        end
    end

    // Stage data carries no reset; qualified by the valids
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_x_q <= s1_x_d;
            s2_y_q <= s2_y_d;
            s3_z_q <= s3_z_d;
        end
    end

endmodule

// File: tb/tb_cfu_requant.sv
// Self-checking bench for cfu_requant: arithmetic reference model plus directed literals.
module tb_cfu_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        in_flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    always #5 clk = ~clk;

    cfu_requant dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_acc    (in_acc),
        .in_flush  (in_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;

    // Shadow of the configuration as software believes it to be
    int bias_m, mult_m, shift_m, off_m, amin_m, amax_m;

    logic [31:0] exp_q[$];
    logic [31:0] pw_m;
    int          lane_m;
    bit          held_v;
    logic [31:0] held_d;

    int rdy_mode;   // 0 always ready, 1 random, 3 stall window
    int wcyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_defaults();
        bias_m = 0; mult_m = 32'h4000_0000; shift_m = 0; off_m = 0;
        amin_m = -128; amax_m = 127;
    endtask

    // Requantized int8 value from plain integer arithmetic
    function automatic logic [7:0] model_byte(input logic [31:0] acc);
        int     x, y, z, w;
        longint p, q;
        logic [31:0] wl;
        x = int'(acc) + bias_m;
        if (shift_m > 0) x = x << shift_m;
        if (x == 32'h8000_0000 && mult_m == 32'h8000_0000) begin
            y = 32'h7FFF_FFFF;
        end else begin
            p = longint'(x) * longint'(mult_m);
            p = p + ((p >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30)));
            y = int'(p >>> 31);
        end
        z = y;
        if (shift_m < 0) begin
            q = (y < 0) ? -longint'(y) : longint'(y);
            q = (q + (longint'(1) << (-shift_m - 1))) >> (-shift_m);
            z = (y < 0) ? int'(-q) : int'(q);
        end
        w = z + off_m;
        if (w < amin_m) w = amin_m;
        else if (w > amax_m) w = amax_m;
        wl = w;
        return wl[7:0];
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] acc);
        logic [7:0] b;
        b = model_byte(acc);
        return {{24{b[7]}}, b};
    endfunction

    // Scoreboard: model on accept, compare on transfer, stall hold and in_ready every cycle
    always @(negedge clk) begin
        logic [7:0] b;
        if (reset) begin
            exp_q.delete();
            pw_m   = '0;
            lane_m = 0;
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_hold_valid", 32'(out_valid), 32'd1);
                check("stall_hold_data", out_data, held_d);
            end
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_output: actual=%h required=none", out_data);
                end else begin
                    check("stream_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                b = model_byte(in_acc);
`ifdef CFU_REQUANT_PACK_EN
                pw_m = pw_m | (32'(b) << (8 * lane_m));
                lane_m++;
                if (lane_m == 4 || in_flush) begin
                    exp_q.push_back(pw_m);
                    pw_m   = '0;
                    lane_m = 0;
                end
`else
                exp_q.push_back({{24{b[7]}}, b});
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wcyc++;
        case (rdy_mode)
            1:       out_ready = ($urandom_range(0, 9) < 7);
            3:       out_ready = !(wcyc >= 5 && wcyc <= 7);
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic cfg(input int sel, input logic [31:0] d);
        cfg_valid = 1'b1; cfg_sel = 3'(sel); cfg_data = d;
        tick();
        cfg_valid = 1'b0;
        case (sel)
            0: bias_m  = int'(d);
            1: mult_m  = int'(d);
            2: shift_m = int'({{26{d[5]}}, d[5:0]});
            3: off_m   = int'(d);
            4: amin_m  = int'(d);
            5: amax_m  = int'(d);
            default: ;
        endcase
    endtask

    task automatic send(input logic [31:0] a, input logic f);
        bit ok;
        int n;
        in_valid = 1'b1; in_acc = a; in_flush = f;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 500);
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: actual=in_ready_low required=accept");
        end
        in_valid = 1'b0; in_flush = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_out(input string name, input logic [31:0] req, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
            @(negedge clk);
        end
        check(name, out_data, req);
        tick();
    endtask

    task automatic single(input string name, input logic [31:0] a, input logic [31:0] req);
        int lat;
        send(a, 1'b0);
        wait_out(name, req, lat);
        check({name, "_latency"}, 32'(lat), 32'd4);
    endtask

    initial begin
        int lat;
        int sh;
        reset = 1'b1; cfg_valid = 1'b0; cfg_sel = '0; cfg_data = '0;
        in_valid = 1'b0; in_acc = '0; in_flush = 1'b0; out_ready = 1'b1;
        rdy_mode = 0; wcyc = 0;
        set_defaults();
        tick(); tick();
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", out_data, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        reset = 1'b0;

        // Model pins against hand-derived values
        check("pin_identity", model_word(32'd100), 32'h0000_0032);
        check("pin_neg_default", model_word(-32'sd1000), 32'hFFFF_FF80);

`ifndef CFU_REQUANT_PACK_EN
        single("identity_100", 32'd100, 32'h0000_0032);
        single("neg1000_default", -32'sd1000, 32'hFFFF_FF80);
        cfg(1, 32'h7FFF_FFFF); cfg(2, 32'h0000_003E); cfg(0, 32'd10); cfg(3, -32'sd5);
        single("cfg_example", 32'd90, 32'h0000_0014);
        set_defaults();
        cfg(0, 0); cfg(2, 0); cfg(3, 0); cfg(1, 32'h8000_0000);
        single("sat_min_min", 32'h8000_0000, 32'h0000_007F);
        single("neg1000_minmult", -32'sd1000, 32'h0000_007F);
        cfg(6, 32'hDEAD_BEEF);
        cfg(7, 32'h1234_5678);
        cfg(1, 32'h4000_0000);
        single("sel67_ignored", 32'd100, 32'h0000_0032);
`else
        cfg(1, 32'h7FFF_FFFF);
        send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b0); send(32'd4, 1'b0);
        wait_out("pack_four", 32'h0403_0201, lat);
        send(32'd5, 1'b1);
        wait_out("pack_flush", 32'h0000_0005, lat);
`endif
        drain();

        // Eight back-to-back inputs with a three-cycle output stall
        cfg(1, 32'h7FFF_FFFF); cfg(2, 32'h0000_003F);
        rdy_mode = 3; wcyc = 0;
        for (int i = 0; i < 8; i++) send(32'(i * 37 - 100), 1'b0);
        rdy_mode = 0;
`ifdef CFU_REQUANT_PACK_EN
        send(32'd7, 1'b1);
`endif
        drain();

        // Reset with three elements in flight restores config defaults
        send(32'd11, 1'b0); send(32'd22, 1'b0); send(32'd33, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("inflight_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;
        set_defaults();
`ifndef CFU_REQUANT_PACK_EN
        single("post_reset_default", 32'd100, 32'h0000_0032);
`else
        for (int i = 0; i < 4; i++) send(32'd100, 1'b0);
        wait_out("post_reset_pack", 32'h3232_3232, lat);
`endif
        drain();

        // Randomized configurations and traffic
        for (int k = 0; k < 5; k++) begin
            rdy_mode = 0;
            drain();
            case ($urandom_range(0, 3))
                0:       cfg(1, 32'h7FFF_FFFF);
                1:       cfg(1, 32'h8000_0000);
                2:       cfg(1, 32'h4000_0000 + 32'($urandom_range(0, 65535)));
                default: cfg(1, $urandom);
            endcase
            sh = int'($urandom_range(0, 62)) - 31;
            cfg(2, 32'(sh));
            cfg(0, ($urandom_range(0, 3) == 0) ? $urandom : 32'(int'($urandom_range(0, 2000)) - 1000));
            cfg(3, 32'(int'($urandom_range(0, 255)) - 128));
            cfg(4, 32'(-128 + int'($urandom_range(0, 120))));
            cfg(5, 32'(amin_m + int'($urandom_range(0, 32'(127 - amin_m)))));
            rdy_mode = 1;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send(($urandom_range(0, 1) == 0) ? $urandom
                                                 : 32'(int'($urandom_range(0, 10000)) - 5000),
                     ($urandom_range(0, 9) == 0) || (i == 59));
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
